ram64_bist: RTL and testbench
=============================

# ram64_bist

Built-in self-test engine that acts as the initiator on the `ram64` port (address/in/load driven, out returned). On `start` it runs a four-phase march over all 64 words:
- write a seed-derived pattern, then read and check it;
- write the complement, then read and check again.

It reports pass/fail, mismatch count and first failing address. It sits between the test/boot sequencer and a `ram64` instance, muxed ahead of the normal CPU port.

## Interface
Parameters:
- none (depth fixed at 64, word 16 bits)

Ports:
- `clk` input 1: system clock, rising-edge
- `rst_n` input 1: asynchronous, active-low reset
- `start` input 1: level, sampled only in IDLE or DONE
- `seed` input 16: pattern seed, latched on accepted start
- `ram_address` output 6: to ram64 `address`
- `ram_in` output 16: to ram64 `in`
- `ram_load` output 1: to ram64 `load`
- `ram_out` input 16: from ram64 `out`; combinational read of `ram_address`
- `busy` output 1: test in progress
- `done` output 1: sticky, set at end of test, cleared by the next accepted start
- `pass` output 1: valid while `done`=1; 1 iff no mismatch
- `fail_count` output 8: mismatches in this run, 0..128
- `first_fail_valid` output 1: at least one mismatch recorded
- `first_fail_address` output 6: address of the first mismatch

## Operation
- States: IDLE, W0, R0, W1, R1, DONE.
- Address counter `a` (6 bits) runs 0..63 in each phase. It wraps to 0 on the phase change.
- Pattern P(a) = seed_latched + {10'b0, a}, computed mod 2^16.
- Each phase drives:
  - W0: `ram_load`=1, `ram_in`=P(a).
  - R0: `ram_load`=0, compare `ram_out` to P(a).
  - W1: `ram_load`=1, `ram_in`=~P(a).
  - R1: `ram_load`=0, compare `ram_out` to ~P(a).
- `ram_load`=0 in IDLE, DONE and both R states. `ram_in`=0 whenever `ram_load`=0.
- Transitions:
  - IDLE/DONE→W0 when `start`=1. On this transition: latch seed; clear fail_count, first_fail_valid, first_fail_address, done and pass.
  - Each phase→next phase when a=63.
  - R1 at a=63→DONE.
- Compare is sampled at the rising edge ending each R cycle. On a mismatch:
  - fail_count increments (max 128, no overflow possible);
  - if first_fail_valid=0, set it and capture `a`.
- A mismatch in R1 at an address that already failed in R0 is counted again.
- `start` held high in DONE restarts the test immediately. `start` while busy is ignored.
- `pass` = done & (fail_count==0).

## Timing
- Reset values (asynchronous, take effect without waiting for a clock edge):
  - state IDLE, a=0, `ram_load`=0, `ram_address`=0, `ram_in`=0;
  - busy=0, done=0, pass=0, fail_count=0, first_fail_valid=0, first_fail_address=0.
- Start sampled at edge E0. Cycle 1 (after E0) is W0 at a=0, with `busy`=1.
- Phase cycles:
  - W0: cycles 1–64
  - R0: cycles 65–128
  - W1: cycles 129–192
  - R1: cycles 193–256
- At the edge ending cycle 256: `done`=1 and `busy`=0, with final counters visible from cycle 257.
- Total busy time is 256 cycles.
- Write commit: ram64 stores `ram_in` at the edge ending the W cycle. The same word is read 64 cycles later.
- Read latency is 0. `ram_out` must settle within the cycle in which `ram_address` is driven.
- `ram_address`, `ram_load` and state come from registers. `ram_in` is combinational from registered state, `a` and seed_latched only.
- Reset mid-test: `ram_load` drops immediately and all counters clear. A subsequent start runs a full clean test.

## Structure
- Shared package `ram_pkg`:
  - constants RAM64_DEPTH=64, RAM_ADDR_W=6, RAM_DATA_W=16;
  - state encoding constants for the six BIST states.
- One natural sub-module, `bist_pattern_gen`: combinational P(a)/~P(a) from seed_latched, a and phase bit.
- Everything else (FSM, counter, compare, result registers) lives in `ram64_bist`.
- The bench instantiates the real `ram64` plus a fault-injecting wrapper.

## Test plan
- Reset: assert `rst_n`=0 mid-clock → all outputs at reset values before the next edge; `ram_load`=0.
- Fault-free ram64, seed 0x1234:
  - W0 writes 0x1234 at address 0 and 0x1273 at address 63; W1 writes 0xEDCB at address 0.
  - `done` rises 256 cycles after start; pass=1, fail_count=0, first_fail_valid=0.
- Bit 0 of word 5 stuck at 0, seed 0x0001:
  - R0 passes, since P(5)=0x0006.
  - R1 fails, since ~P(5)=0xFFF9.
  - Result: fail_count=1, first_fail_address=5, pass=0.
- Seed wrap, seed 0xFFF0: write at address 63 is 0x002F, W1 address 63 is 0xFFD0; fault-free → pass=1.
- Start pulse at cycle 100 of a running test: ignored, and done still occurs at cycle 256. `start` held high through DONE: second run begins the cycle after done, and counters clear.
- `rst_n` pulsed low at cycle 70 (R0): `ram_load`=0 and busy=0 immediately. A new start with seed 0x0000 completes with pass=1.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and BIST state encoding for the ram64 word memory and its
// built-in self-test engine.
package ram_pkg;

  localparam int RAM64_DEPTH = 64;
  localparam int RAM_ADDR_W  = 6;
  localparam int RAM_DATA_W  = 16;

  localparam logic [RAM_ADDR_W-1:0] RAM_ADDR_LAST = RAM_ADDR_W'(RAM64_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_R0   = 3'd2,
    ST_W1   = 3'd3,
    ST_R1   = 3'd4,
    ST_DONE = 3'd5
  } bist_state_e;

  function automatic logic is_write_state(input bist_state_e s);
    return (s == ST_W0) || (s == ST_W1);
  endfunction

  function automatic logic is_read_state(input bist_state_e s);
    return (s == ST_R0) || (s == ST_R1);
  endfunction

  // The second half of the march uses the complemented pattern.
  function automatic logic is_invert_state(input bist_state_e s);
    return (s == ST_W1) || (s == ST_R1);
  endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// March data pattern: P(a) = seed + a (mod 2^16), optionally complemented.
module bist_pattern_gen
  import ram_pkg::*;
(
  input  logic [RAM_DATA_W-1:0] seed_i,
  input  logic [RAM_ADDR_W-1:0] addr_i,
  input  logic                  invert_i,
  output logic [RAM_DATA_W-1:0] pattern_o
);

  logic [RAM_DATA_W-1:0] base;

  assign base      = seed_i + {{(RAM_DATA_W-RAM_ADDR_W){1'b0}}, addr_i};
  assign pattern_o = invert_i ? ~base : base;

endmodule

// File: rtl/ram64.sv
// 64 x 16 word memory: synchronous write on load, combinational read of address.
module ram64
  import ram_pkg::*;
(
  input  logic                  clk,
  input  logic [RAM_ADDR_W-1:0] address,
  input  logic [RAM_DATA_W-1:0] in,
  input  logic                  load,
  output logic [RAM_DATA_W-1:0] out
);

  logic [RAM_DATA_W-1:0] mem_q [RAM64_DEPTH];

  // NOTE: the storage array has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (load) begin
      mem_q[address] <= in;
    end
  end

  assign out = mem_q[address];

endmodule

// File: rtl/ram64_bist.sv
// Four-phase march BIST initiator for ram64: write P, read P, write ~P, read ~P,
// reporting pass/fail, mismatch count and first failing address.
module ram64_bist
  import ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [RAM_DATA_W-1:0] seed,
  output logic [RAM_ADDR_W-1:0] ram_address,
  output logic [RAM_DATA_W-1:0] ram_in,
  output logic                  ram_load,
  input  logic [RAM_DATA_W-1:0] ram_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            fail_count,
  output logic                  first_fail_valid,
  output logic [RAM_ADDR_W-1:0] first_fail_address
);

  bist_state_e           state_q, state_d;
  logic [RAM_ADDR_W-1:0] a_q, a_d;
  logic [RAM_DATA_W-1:0] seed_q, seed_d;
  logic [7:0]            fail_count_q, fail_count_d;
  logic                  ffv_q, ffv_d;
  logic [RAM_ADDR_W-1:0] ffa_q, ffa_d;
  logic                  done_q, done_d;
  logic                  load_q, load_d;

  logic [RAM_DATA_W-1:0] pattern;
  logic                  mismatch;

  bist_pattern_gen u_pattern (
    .seed_i    (seed_q),
    .addr_i    (a_q),
    .invert_i  (is_invert_state(state_q)),
    .pattern_o (pattern)
  );

  // Read latency is zero, so ram_out belongs to the address driven this cycle.
  assign mismatch = is_read_state(state_q) && (ram_out != pattern);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    seed_d       = seed_q;
    fail_count_d = fail_count_q;
    ffv_d        = ffv_q;
    ffa_d        = ffa_q;
    done_d       = done_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_W0;
          a_d          = '0;
          seed_d       = seed;
          fail_count_d = '0;
          ffv_d        = 1'b0;
          ffa_d        = '0;
          done_d       = 1'b0;
        end
      end
      ST_W0: begin
        a_d = a_q + 1'b1;
        if (a_q == RAM_ADDR_LAST) state_d = ST_R0;
      end
      ST_R0: begin
        a_d = a_q + 1'b1;
        if (a_q == RAM_ADDR_LAST) state_d = ST_W1;
      end
      ST_W1: begin
        a_d = a_q + 1'b1;
        if (a_q == RAM_ADDR_LAST) state_d = ST_R1;
      end
      ST_R1: begin
        a_d = a_q + 1'b1;
        if (a_q == RAM_ADDR_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        a_d     = '0;
      end
    endcase

    // At most 128 reads per run, so the 8-bit counter cannot overflow.
    if (mismatch) begin
      fail_count_d = fail_count_q + 8'd1;
      if (!ffv_q) begin
        ffv_d = 1'b1;
        ffa_d = a_q;
      end
    end

    load_d = is_write_state(state_d);
  end

  // NOTE: state registers use non-blocking assignments so all update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      seed_q       <= '0;
      fail_count_q <= '0;
      ffv_q        <= 1'b0;
      ffa_q        <= '0;
      done_q       <= 1'b0;
      load_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      seed_q       <= seed_d;
      fail_count_q <= fail_count_d;
      ffv_q        <= ffv_d;
      ffa_q        <= ffa_d;
      done_q       <= done_d;
      load_q       <= load_d;
    end
  end

  assign ram_address        = a_q;
  assign ram_load           = load_q;
  assign ram_in             = load_q ? pattern : '0;
  assign busy               = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done               = done_q;
  assign pass               = done_q && (fail_count_q == 8'd0);
  assign fail_count         = fail_count_q;
  assign first_fail_valid   = ffv_q;
  assign first_fail_address = ffa_q;

endmodule

// File: tb/tb_ram64_bist.sv
// Self-checking bench for ram64_bist driving a real ram64 through a read-path
// fault injector; writes are scoreboarded, results are checked per vector.
module tb_ram64_bist;
  import ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] seed;
  logic [5:0]  ram_address;
  logic [15:0] ram_in, ram_out, mem_out;
  logic        ram_load, busy, done, pass, first_fail_valid;
  logic [7:0]  fail_count;
  logic [5:0]  first_fail_address;

  always #5 clk = ~clk;

  ram64_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_valid(first_fail_valid), .first_fail_address(first_fail_address)
  );

  ram64 u_ram (
    .clk(clk), .address(ram_address), .in(ram_in), .load(ram_load), .out(mem_out)
  );

  typedef enum int {F_NONE, F_STUCK0, F_STUCK1, F_FLIP} fault_e;
  fault_e     fault_kind = F_NONE;
  logic       fault_all  = 1'b0;
  logic [5:0] fault_addr = '0;
  logic [3:0] fault_bit  = '0;

  always_comb begin
    ram_out = mem_out;
    if (fault_kind != F_NONE && (fault_all || ram_address == fault_addr)) begin
      case (fault_kind)
        F_STUCK0: ram_out[fault_bit] = 1'b0;
        F_STUCK1: ram_out[fault_bit] = 1'b1;
        F_FLIP:   ram_out[fault_bit] = ~mem_out[fault_bit];
        default:  ram_out = mem_out;
      endcase
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [5:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t sb[$];

  task automatic push_run(input logic [15:0] s);
    logic [15:0] p;
    for (int i = 0; i < 64; i++) begin
      p = s + 16'(i);
      sb.push_back('{a: 6'(i), d: p});
    end
    for (int i = 0; i < 64; i++) begin
      p = s + 16'(i);
      sb.push_back('{a: 6'(i), d: ~p});
    end
  endtask

  // Write monitor: every load cycle must match the next expected write.
  always @(negedge clk) begin
    wr_t w;
    if (rst_n === 1'b1) begin
      if (ram_load === 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_write", 32'(ram_address), 32'hFFFF_FFFF);
        end else begin
          w = sb.pop_front();
          check("wr_addr", 32'(ram_address), 32'(w.a));
          check("wr_data", 32'(ram_in), 32'(w.d));
        end
      end else begin
        check("ram_in_idle_zero", 32'(ram_in), 32'h0);
      end
    end
  end

  // Starts a run and returns the cycle number in which done is first seen.
  task automatic do_run(input logic [15:0] s, input int pulse_at, input bit hold, output int cyc);
    push_run(s);
    seed  = s;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    cyc = 1;
    check("busy_cycle1", 32'(busy), 32'h1);
    check("done_cleared", 32'(done), 32'h0);
    while (done !== 1'b1 && cyc < 300) begin
      if (cyc == pulse_at) begin
        start = 1'b1;
        seed  = ~s;
      end else if (!hold) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_res(input string tag, input bit ep, input int efc,
                           input bit effv, input logic [5:0] effa);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_pass"}, 32'(pass), 32'(ep));
    check({tag, "_fail_count"}, 32'(fail_count), 32'(efc));
    check({tag, "_ffv"}, 32'(first_fail_valid), 32'(effv));
    check({tag, "_ffa"}, 32'(first_fail_address), 32'(effa));
  endtask

  typedef struct {
    logic [15:0] seed;
    fault_e      kind;
    logic        all;
    logic [5:0]  faddr;
    logic [3:0]  fbit;
    bit          exp_pass;
    int          exp_fc;
    bit          exp_ffv;
    logic [5:0]  exp_ffa;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc;

    vecs[0] = '{16'h1234, F_NONE,   1'b0, 6'd0,  4'd0,  1'b1, 0,   1'b0, 6'd0};
    vecs[1] = '{16'h0001, F_STUCK0, 1'b0, 6'd5,  4'd0,  1'b0, 1,   1'b1, 6'd5};
    vecs[2] = '{16'hFFF0, F_NONE,   1'b0, 6'd0,  4'd0,  1'b1, 0,   1'b0, 6'd0};
    vecs[3] = '{16'h0000, F_STUCK1, 1'b0, 6'd10, 4'd15, 1'b0, 1,   1'b1, 6'd10};
    vecs[4] = '{16'h00FF, F_STUCK0, 1'b0, 6'd63, 4'd3,  1'b0, 1,   1'b1, 6'd63};
    vecs[5] = '{16'h0000, F_STUCK0, 1'b1, 6'd0,  4'd0,  1'b0, 64,  1'b1, 6'd1};
    vecs[6] = '{16'h0000, F_STUCK1, 1'b1, 6'd0,  4'd6,  1'b0, 64,  1'b1, 6'd0};
    vecs[7] = '{16'hABCD, F_FLIP,   1'b1, 6'd0,  4'd9,  1'b0, 128, 1'b1, 6'd0};

    rst_n = 1'b1;
    start = 1'b0;
    seed  = '0;

    // Asynchronous reset asserted mid-cycle, checked before the next edge.
    #12 rst_n = 1'b0;
    #1;
    check("rst_ram_load", 32'(ram_load), 32'h0);
    check("rst_ram_address", 32'(ram_address), 32'h0);
    check("rst_ram_in", 32'(ram_in), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pass", 32'(pass), 32'h0);
    check("rst_fail_count", 32'(fail_count), 32'h0);
    check("rst_ffv", 32'(first_fail_valid), 32'h0);
    check("rst_ffa", 32'(first_fail_address), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      fault_kind = vecs[i].kind;
      fault_all  = vecs[i].all;
      fault_addr = vecs[i].faddr;
      fault_bit  = vecs[i].fbit;
      do_run(vecs[i].seed, 0, 1'b0, cyc);
      check($sformatf("v%0d_done_cycle", i), 32'(cyc), 32'd257);
      check_res($sformatf("v%0d", i), vecs[i].exp_pass, vecs[i].exp_fc,
                vecs[i].exp_ffv, vecs[i].exp_ffa);
      check($sformatf("v%0d_sb_empty", i), 32'(sb.size()), 32'd0);
      @(negedge clk);
    end

    // Start pulse (with a different seed) mid-test is ignored.
    fault_kind = F_NONE;
    do_run(16'h5A5A, 100, 1'b0, cyc);
    check("pulse_done_cycle", 32'(cyc), 32'd257);
    check_res("pulse", 1'b1, 0, 1'b0, 6'd0);
    check("pulse_sb_empty", 32'(sb.size()), 32'd0);

    // Start held through DONE: immediate restart with cleared counters.
    fault_kind = F_STUCK0; fault_all = 1'b0; fault_addr = 6'd5; fault_bit = 4'd0;
    do_run(16'h0001, 0, 1'b1, cyc);
    check("hold_done_cycle", 32'(cyc), 32'd257);
    check_res("hold1", 1'b0, 1, 1'b1, 6'd5);
    push_run(16'h0001);
    fault_kind = F_NONE;
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_restart_busy", 32'(busy), 32'h1);
    check("hold_restart_done", 32'(done), 32'h0);
    check("hold_restart_fc", 32'(fail_count), 32'h0);
    check("hold_restart_ffv", 32'(first_fail_valid), 32'h0);
    check("hold_restart_load", 32'(ram_load), 32'h1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hold2_done_cycle", 32'(cyc), 32'd257);
    check_res("hold2", 1'b1, 0, 1'b0, 6'd0);

    // Reset in R0 at cycle 70, then a clean run.
    @(negedge clk);
    fault_kind = F_FLIP; fault_all = 1'b1; fault_bit = 4'd2;
    push_run(16'h4321);
    seed  = 16'h4321;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    check("mid_fc_before_rst", 32'(fail_count), 32'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_load", 32'(ram_load), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_fc", 32'(fail_count), 32'h0);
    check("mid_rst_ffv", 32'(first_fail_valid), 32'h0);
    check("mid_rst_addr", 32'(ram_address), 32'h0);
    sb.delete();
    fault_kind = F_NONE;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    do_run(16'h0000, 0, 1'b0, cyc);
    check("post_rst_done_cycle", 32'(cyc), 32'd257);
    check_res("post_rst", 1'b1, 0, 1'b0, 6'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
